// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_ctrl_pkg : shared types and constants for the multiplier-sharing controller
// rev 1.0
// ---------------------------------------------------------------------------
package mul_ctrl_pkg;

    localparam int c_WIDTH_DEFAULT   = 32;
    localparam int c_TIMEOUT_DEFAULT = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // Counter must hold TIMEOUT-1; never let the width collapse to zero.
    function automatic int tmo_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : combinational two-way round-robin picker, one-hot grant
// rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_share_ctrl : shares one sequential signed multiplier between two requesters
// rev 1.0
// ---------------------------------------------------------------------------
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH   = c_WIDTH_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [WIDTH-1:0]     m_multiplier,
    output logic [WIDTH-1:0]     m_multiplicand,
    output logic                 m_op_start,
    output logic                 m_op_clear,
    input  logic                 m_op_done,
    input  logic [2*WIDTH-1:0]   m_result
);

    localparam int                 c_CNT_W    = tmo_cnt_width(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last;
    logic [1:0]         w_gnt;
    logic               w_load;
    logic               w_done;
    logic               w_tmo;
    logic               w_start_nxt;
    logic               w_clear_nxt;
    logic [1:0]         w_ack_nxt;
    logic               w_busy_nxt;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign w_load = (r_state == IDLE) && (w_gnt != 2'b00);
    assign w_done = (r_state == WAIT) && m_op_done;
    assign w_tmo  = (r_state == WAIT) && !m_op_done && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = START;
            START:   w_state_nxt = WAIT;
            WAIT:    if (w_done || w_tmo) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port leaves a flop.
    always_comb begin
        w_start_nxt = (r_state == IDLE) && (w_state_nxt == START);
        w_clear_nxt = (r_state == WAIT) && (w_state_nxt == CLEAR);
        w_ack_nxt   = 2'b00;
        if (w_done || w_tmo) begin
            w_ack_nxt = r_last ? 2'b10 : 2'b01;
        end
        w_busy_nxt  = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_op_start     <= 1'b0;
            m_op_clear     <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            err            <= 1'b0;
            busy           <= 1'b0;
            result         <= '0;
            m_multiplier   <= '0;
            m_multiplicand <= '0;
            r_last         <= 1'b1;
            r_cnt          <= '0;
        end else begin
            m_op_start <= w_start_nxt;
            m_op_clear <= w_clear_nxt;
            ack0       <= w_ack_nxt[0];
            ack1       <= w_ack_nxt[1];
            err        <= w_tmo;
            busy       <= w_busy_nxt;

            // r_last doubles as the owner of the operation in flight.
            if (w_load) begin
                m_multiplier   <= w_gnt[1] ? a1 : a0;
                m_multiplicand <= w_gnt[1] ? b1 : b0;
                r_last         <= w_gnt[1];
            end

            if (w_done) begin
                result <= m_result;
            end else if (w_tmo) begin
                result <= '0;
            end

            if (r_state == START) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_share_ctrl : directed and randomized self-checking bench with a stub multiplier
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mul_share_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        ack0;
    logic        ack1;
    logic        err;
    logic        busy;
    logic [63:0] result;
    logic [31:0] m_multiplier;
    logic [31:0] m_multiplicand;
    logic        m_op_start;
    logic        m_op_clear;
    logic        m_op_done = 1'b0;
    logic [63:0] m_result = '0;

    int n_vec = 0;
    int n_err = 0;
    bit exp_last = 1'b1;

    mul_share_ctrl #(.WIDTH(32), .TIMEOUT(128)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0           (req0),
        .req1           (req1),
        .a0             (a0),
        .b0             (b0),
        .a1             (a1),
        .b1             (b1),
        .ack0           (ack0),
        .ack1           (ack1),
        .err            (err),
        .result         (result),
        .busy           (busy),
        .m_multiplier   (m_multiplier),
        .m_multiplicand (m_multiplicand),
        .m_op_start     (m_op_start),
        .m_op_clear     (m_op_clear),
        .m_op_done      (m_op_done),
        .m_result       (m_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One whole operation, starting in a cycle where the controller is idle.
    // The winner, operands and product come from the arbitration rule and plain
    // signed arithmetic; hang keeps the stub multiplier silent.
    task automatic serve(input int lat, input bit hang, input bit glitch);
        int          w;
        int          nw;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [63:0] ep;
        if (req0 && req1)  w = exp_last ? 0 : 1;
        else if (req0)     w = 0;
        else               w = 1;
        ea = (w == 1) ? a1 : a0;
        eb = (w == 1) ? b1 : b0;
        ep = hang ? 64'd0 : prod(ea, eb);
        exp_last = (w == 1);
        nw = hang ? 128 : lat + 1;

        tick();
        chk("start_pulse", m_op_start, 1'b1);
        chk("busy_start", busy, 1'b1);
        chk("op_a", m_multiplier, ea);
        chk("op_b", m_multiplicand, eb);
        if (w == 0) begin a0 = $urandom; b0 = $urandom; end
        else        begin a1 = $urandom; b1 = $urandom; end

        for (int k = 1; k <= nw; k++) begin
            tick();
            chk("wait_quiet", {ack1, ack0, err, m_op_start, m_op_clear}, 5'b0);
            if (glitch && k == 1) begin
                if (w == 0) begin req1 = 1'b1; a1 = $urandom; end
                else        begin req0 = 1'b1; a0 = $urandom; end
            end
            if (glitch && k == 2) begin
                if (w == 0) req1 = 1'b0;
                else        req0 = 1'b0;
            end
            if (!hang && k == nw) begin
                m_op_done = 1'b1;
                m_result  = prod(ea, eb);
            end
        end

        tick();
        chk("ack_vec", {ack1, ack0}, (w == 1) ? 2'b10 : 2'b01);
        chk("err", err, hang);
        chk("result", result, ep);
        chk("clear_pulse", m_op_clear, 1'b1);
        chk("op_a_hold", m_multiplier, ea);
        if (w == 0) req0 = 1'b0;
        else        req1 = 1'b0;

        tick();
        m_op_done = 1'b0;
        chk("idle_after", {ack1, ack0, err, m_op_start, m_op_clear, busy}, 6'b0);
    endtask

    initial begin
        int r;
        int guard;

        tick();
        tick();
        chk("rst_outs", {ack0, ack1, err, busy, m_op_start, m_op_clear}, 6'b0);
        chk("rst_result", result, 64'd0);
        chk("rst_ops", {m_multiplier, m_multiplicand}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Multiplier done while idle must not produce anything.
        m_op_done = 1'b1;
        m_result  = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_done_ignored", {ack1, ack0, busy, m_op_start}, 4'b0);
        end
        m_op_done = 1'b0;
        tick();

        // Simultaneous pair right after reset: req0 first, then req1.
        req0 = 1'b1; a0 = -32'sd5; b0 = -32'sd7;
        req1 = 1'b1; a1 = 32'sd9;  b1 = -32'sd2;
        serve(3, 1'b0, 1'b0);
        chk("tie_res0", result, 64'd35);
        serve(5, 1'b0, 1'b0);
        chk("tie_res1", result, 64'hFFFF_FFFF_FFFF_FFEE);

        // Single req0; a short req1 pulse while busy must be forgotten.
        req0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
        serve(4, 1'b0, 1'b1);
        chk("single_res", result, 64'd15);
        tick();
        chk("dropped_req_ignored", {busy, m_op_start, ack1}, 3'b0);

        // Second simultaneous pair, now req1 is favoured.
        req0 = 1'b1; a0 = 32'd11;  b0 = 32'd12;
        req1 = 1'b1; a1 = -32'sd3; b1 = 32'd4;
        serve(2, 1'b0, 1'b0);
        chk("tie2_first_res", result, 64'hFFFF_FFFF_FFFF_FFF4);
        serve(1, 1'b0, 1'b0);
        chk("tie2_second_res", result, 64'd132);

        req1 = 1'b1; a1 = 32'd0; b1 = 32'hFFFF_FFFB;
        serve(2, 1'b0, 1'b0);
        chk("zero_res", result, 64'd0);

        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(1, 3);
            a0 = rnd_op(); b0 = rnd_op();
            a1 = rnd_op(); b1 = rnd_op();
            req0 = r[0];
            req1 = r[1];
            guard = 0;
            while ((req0 || req1) && guard < 3) begin
                serve($urandom_range(0, 12), 1'b0, 1'b0);
                guard++;
            end
        end

        req0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
        serve(0, 1'b1, 1'b0);
        chk("timeout_res", result, 64'd0);

        // Reset in WAIT clears everything at once.
        req0 = 1'b1; a0 = 32'd123; b0 = 32'd456;
        tick();
        tick();
        tick();
        chk("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0;
        m_op_done = 1'b0;
        #1;
        chk("async_rst_outs", {ack0, ack1, err, busy, m_op_start, m_op_clear}, 6'b0);
        chk("async_rst_ops", {m_multiplier, m_multiplicand}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        req0 = 1'b0;
        exp_last = 1'b1;
        tick();
        tick();
        chk("in_rst_quiet", {ack0, ack1, m_op_clear, busy}, 4'b0);
        reset_n = 1'b1;
        tick();
        req0 = 1'b1; a0 = -32'sd5; b0 = 32'sd5;
        serve(4, 1'b0, 1'b0);
        chk("post_rst_res", result, 64'hFFFF_FFFF_FFFF_FFE7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Controller that shares one sequential signed 32×32 multiplier between two requesters. It arbitrates round-robin and latches the winner's operands. It then sequences the multiplier's op_start / op_done / op_clear handshake and returns the 64-bit product with a per-requester acknowledge. The block sits between the two client datapaths and the single multiplier instance, and drives the multiplier's clk/reset_n from the same sources.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- TIMEOUT, 128, max cycles in WAIT before abort; must be > multiplier worst-case latency
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req0, req1  in  1  request level; held high until matching ack, dropped the cycle after ack
- a0, b0, a1, b1  in  WIDTH  multiplier/multiplicand of each requester; sampled only at grant
- ack0, ack1  out  1  one-cycle pulse: product for that requester valid on result
- err  out  1  one-cycle pulse with ack when operation timed out (result forced 0)
- result  out  2*WIDTH  last product, held until next ack
- busy  out  1  high in any state other than IDLE
- m_multiplier, m_multiplicand  out  WIDTH  operands to multiplier, registered
- m_op_start, m_op_clear  out  1  one-cycle pulses to multiplier
- m_op_done  in  1  multiplier done level, high until op_clear
- m_result  in  2*WIDTH  multiplier product, valid while m_op_done high

## Operation
- FSM states: IDLE, START, WAIT, CLEAR.
- IDLE: if req0|req1, pick a winner, latch its a/b into m_multiplier/m_multiplicand, record grant, then go to START. Otherwise stay.
- Arbitration: if only one request is pending, it wins. If both are pending, the requester not granted last time wins. After reset the last grant is 1, so req0 wins the first tie.
- START: m_op_start=1 for exactly one cycle. Reset the timeout counter. Go to WAIT.
- WAIT: the counter increments each cycle. If m_op_done=1, register m_result into result, pulse ack[grant], and go to CLEAR.
- Timeout in WAIT: if the counter reaches TIMEOUT-1 without m_op_done, result=0, pulse ack[grant] and err together, and go to CLEAR.
- CLEAR: m_op_clear=1 for exactly one cycle. Go to IDLE.
- Operands are stable on m_* from grant until the next grant. Requester inputs may change freely after grant.
- A request that drops before grant is ignored. Dropping req after grant does not abort the operation.
- m_op_done high in IDLE or START is ignored and does not produce an ack.
- Product is the signed two's-complement 2*WIDTH result passed through unchanged. No truncation.

## Timing
- Reset values: ack0=ack1=err=busy=0; m_op_start=m_op_clear=0; result=0; m_multiplier=m_multiplicand=0; state=IDLE.
- Reset asserted mid-operation returns to IDLE within the same cycle, with no ack and no clear pulse. The multiplier is reset by the same reset_n.
- req high in IDLE at cycle 0 gives m_op_start high in cycle 1 and state WAIT from cycle 2.
- m_op_done first sampled high in cycle d gives ack/result in cycle d+1 and m_op_clear in cycle d+1. State is IDLE in cycle d+2, and the next m_op_start can come at cycle d+3 at the earliest.
- Overhead per operation is 3 cycles plus multiplier latency. Back-to-back operations from alternating requesters have no idle gap beyond that.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package mul_ctrl_pkg: state enum (IDLE, START, WAIT, CLEAR), WIDTH default constant, timeout counter width derived as $clog2(TIMEOUT).
- Sub-module rr_arb2: combinational 2-way round-robin picker (req[1:0], last → gnt[1:0]). The last-grant register lives in the parent.
- Parent module holds the FSM, operand/result registers and the timeout counter.

## Test plan
- Single req0, a0=3, b0=5 → one m_op_start pulse; ack0 after done; result=64'd15; one m_op_clear; ack1 never pulses.
- req0 and req1 both high from the same cycle, with a0=-5, b0=-7 and a1=9, b1=-2 → req0 served first with result=35. req1 is then served with result=-18 (64'hFFFF_FFFF_FFFF_FFEE). Following that, another simultaneous pair is served req1 first.
- Zero operands, a1=0 and b1=32'hFFFF_FFFB → result=0, ack1 pulses, err stays 0.
- Stub multiplier that never raises op_done → after TIMEOUT cycles in WAIT, ack0 and err pulse together, result=0, m_op_clear pulses once, then back to IDLE.
- reset_n pulled low in WAIT → all outputs at reset values immediately, no ack. After release, a new req0 with a0=-5, b0=5 completes with result=-25.
